// File: rtl/pipe_stage_skid_reg.sv
// Purpose: pipeline stage register with an optional second (skid) entry that carries a datapath payload and a control bundle.
// Latency: one cycle from accept to out_valid, with one beat per cycle throughput while downstream is ready.
// Backpressure: SKID=1 gives a registered in_ready that drops only when the skid entry is full; SKID=0 gives in_ready = ~main_valid | fire.
module pipe_stage_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    localparam bit HAS_SKID = (SKID != 0);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic              in_ready_q,   in_ready_d;

    logic fire;
    logic accept;

    // Handshake qualifiers; hold behaves exactly like a deasserted out_ready.
    always_comb begin
        fire     = main_valid_q & out_ready & ~hold;
        in_ready = HAS_SKID ? in_ready_q : (~main_valid_q | fire);
        accept   = in_valid & in_ready;
    end

    // Next-state for the main and skid entries; flush squashes everything, including this cycle's accept.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
        end else if (!main_valid_q) begin
            // Skid is never occupied while main is empty, so an empty main just takes the new beat.
            if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end
        end else if (fire) begin
            if (skid_valid_q) begin
                // in_ready is low while skid is full, so no accept can race this move.
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = 1'b0;
                skid_data_d  = '0;
                skid_ctrl_d  = '0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end else begin
                main_valid_d = 1'b0;
                main_data_d  = '0;
                main_ctrl_d  = '0;
            end
        end else if (accept && HAS_SKID) begin
            // Main is stalled; park the incoming beat behind it.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end

        // Registered ready: a free skid slot is what guarantees room next cycle.
        in_ready_d = ~skid_valid_d;
    end

    // State registers with asynchronous active-high reset; in_ready comes up asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Downstream view: a bubble always carries an all-zero control bundle so no enable leaks out.
    always_comb begin
        out_valid = main_valid_q;
        out_data  = main_data_q;
        out_ctrl  = main_valid_q ? main_ctrl_q : '0;
        occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    end

endmodule
